// File: rtl/vec_lsu_pkg.sv
// Shared types and helpers for the sequential vector load/store unit.
package vec_lsu_pkg;

    typedef enum logic [1:0] {
        SEW8  = 2'b00,
        SEW16 = 2'b01,
        SEW32 = 2'b10
    } sew_e;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    // Number of elements of the given width that fit in a vlen-bit register.
    function automatic int unsigned elems_per_vlen(input sew_e sew, input int unsigned vlen);
        case (sew)
            SEW8:    return vlen / 8;
            SEW16:   return vlen / 16;
            default: return vlen / 32;
        endcase
    endfunction

    // The reserved encoding 2'b11 behaves as 32-bit elements.
    function automatic sew_e norm_sew(input logic [1:0] raw);
        return (raw == 2'b11) ? SEW32 : sew_e'(raw);
    endfunction

endpackage

// File: rtl/vec_elem_align.sv
// Byte-lane steering for one element: store data/enables, load extract, alignment check.
module vec_elem_align
    import vec_lsu_pkg::*;
(
    input  sew_e        sew,
    input  logic [1:0]  lane,
    input  logic [31:0] elem,
    input  logic [31:0] rdata,
    output logic [31:0] wdata,
    output logic [3:0]  wmem,
    output logic [31:0] ldata,
    output logic        misalign
);

    logic [31:0] shifted;

    // Replicate store data across lanes so the enables alone select the bytes written.
    always_comb begin
        shifted  = rdata >> {lane, 3'b000};
        wdata    = elem;
        wmem     = '1;
        ldata    = rdata;
        misalign = 1'b0;
        case (sew)
            SEW8: begin
                wdata = {4{elem[7:0]}};
                wmem  = 4'b0001 << lane;
                ldata = {24'b0, shifted[7:0]};
            end
            SEW16: begin
                wdata    = {2{elem[15:0]}};
                wmem     = 4'b0011 << lane;
                ldata    = {16'b0, shifted[15:0]};
                misalign = lane[0];
            end
            default: begin
                misalign = (lane != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/vec_lsu_seq.sv
// Sequential vector load/store: one memory access per element, strided, with vl clamp.
module vec_lsu_seq
    import vec_lsu_pkg::*;
#(
    parameter int unsigned VLEN = 128,
    parameter int unsigned VLW  = $clog2(VLEN / 8) + 1
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_store,
    input  logic [1:0]      req_sew,
    input  logic [31:0]     req_base,
    input  logic [31:0]     req_stride,
    input  logic [VLW-1:0]  req_vl,
    input  logic [VLEN-1:0] req_wdata,
    output logic            resp_valid,
    output logic            resp_err,
    output logic [VLEN-1:0] resp_rdata,
    output logic            busy,
    output logic [31:0]     mem_addr,
    output logic            mem_re,
    input  logic [31:0]     mem_rdata,
    output logic [31:0]     mem_wdata,
    output logic [3:0]      mem_wmem
);

    state_e          state, state_n;
    logic            store_q;
    sew_e            sew_q;
    logic [31:0]     addr_q;
    logic [31:0]     stride_q;
    logic [VLW-1:0]  vl_q;
    logic [VLW-1:0]  idx_q;
    logic [VLEN-1:0] wdata_q;
    logic [VLEN-1:0] rdata_q;
    logic            err_q;

    sew_e            sew_n;
    int unsigned     max_el;
    logic [VLW-1:0]  vl_clamped;
    logic [31:0]     shamt;
    logic [VLEN-1:0] wshift;
    logic [31:0]     wdata_al;
    logic [3:0]      wmem_al;
    logic [31:0]     ldata;
    logic [VLEN-1:0] ld_ext;
    logic            misalign;
    logic            last;
    logic            run;

    // Request decode and element positioning within the vector register.
    always_comb begin
        sew_n      = norm_sew(req_sew);
        max_el     = elems_per_vlen(sew_n, VLEN);
        vl_clamped = (32'(req_vl) > max_el) ? VLW'(max_el) : req_vl;
        shamt      = 32'(idx_q) << (32'd3 + 32'(sew_q));
        wshift     = wdata_q >> shamt;
        ld_ext     = VLEN'(ldata) << shamt;
        last       = (idx_q == vl_q - 1'b1);
        run        = (state == RUN);
    end

    vec_elem_align u_align (
        .sew      (sew_q),
        .lane     (addr_q[1:0]),
        .elem     (wshift[31:0]),
        .rdata    (mem_rdata),
        .wdata    (wdata_al),
        .wmem     (wmem_al),
        .ldata    (ldata),
        .misalign (misalign)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (clr) state <= IDLE;
        else     state <= state_n;
    end

    // Next-state logic.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (req_valid) state_n = (vl_clamped == '0) ? DONE : RUN;
            RUN:     if (misalign || last) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Request latch, address accumulator, element counter and load result.
    always_ff @(posedge clk) begin
        if (clr) begin
            store_q  <= 1'b0;
            sew_q    <= SEW8;
            addr_q   <= '0;
            stride_q <= '0;
            vl_q     <= '0;
            idx_q    <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        store_q  <= req_store;
                        sew_q    <= sew_n;
                        addr_q   <= req_base;
                        stride_q <= req_stride;
                        vl_q     <= vl_clamped;
                        idx_q    <= '0;
                        wdata_q  <= req_wdata;
                        err_q    <= 1'b0;
                        if (!req_store) rdata_q <= '0;
                    end
                end
                RUN: begin
                    if (misalign) begin
                        err_q <= 1'b1;
                    end else begin
                        if (!store_q) rdata_q <= rdata_q | ld_ext;
                        idx_q  <= idx_q + 1'b1;
                        addr_q <= addr_q + stride_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready  = (state == IDLE);
    assign busy       = (state != IDLE);
    assign resp_valid = (state == DONE);
    assign resp_err   = (state == DONE) & err_q;
    assign resp_rdata = rdata_q;
    assign mem_addr   = run ? {addr_q[31:2], 2'b00} : '0;
    assign mem_re     = run & ~store_q & ~misalign;
    assign mem_wmem   = (run & store_q & ~misalign) ? wmem_al : '0;
    assign mem_wdata  = (run & store_q) ? wdata_al : '0;

endmodule

// File: tb/tb_vec_lsu_seq.sv
// Directed, table-driven bench for vec_lsu_seq with a small byte-enabled memory model.
module tb_vec_lsu_seq;

    localparam int unsigned VLEN = 128;
    localparam int unsigned VLW  = 5;

    logic            clk = 1'b0;
    logic            clr = 1'b1;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic            req_store = 1'b0;
    logic [1:0]      req_sew = 2'b00;
    logic [31:0]     req_base = '0;
    logic [31:0]     req_stride = '0;
    logic [VLW-1:0]  req_vl = '0;
    logic [VLEN-1:0] req_wdata = '0;
    logic            resp_valid;
    logic            resp_err;
    logic [VLEN-1:0] resp_rdata;
    logic            busy;
    logic [31:0]     mem_addr;
    logic            mem_re;
    logic [31:0]     mem_rdata;
    logic [31:0]     mem_wdata;
    logic [3:0]      mem_wmem;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [256];
    logic        pl_en = 1'b0;
    logic [31:0] pl_addr = '0;
    logic [31:0] pl_data = '0;
    logic [31:0] wr_a [64];
    logic [3:0]  wr_b [64];
    int          wr_cnt = 0;

    always #5 clk = ~clk;

    vec_lsu_seq #(.VLEN(VLEN), .VLW(VLW)) dut (
        .clk        (clk),
        .clr        (clr),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_store  (req_store),
        .req_sew    (req_sew),
        .req_base   (req_base),
        .req_stride (req_stride),
        .req_vl     (req_vl),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_err   (resp_err),
        .resp_rdata (resp_rdata),
        .busy       (busy),
        .mem_addr   (mem_addr),
        .mem_re     (mem_re),
        .mem_rdata  (mem_rdata),
        .mem_wdata  (mem_wdata),
        .mem_wmem   (mem_wmem)
    );

    assign mem_rdata = mem[mem_addr[9:2]];

    // Memory model: preload port plus byte-enabled writes from the DUT, with a write log.
    always @(posedge clk) begin
        if (pl_en) begin
            mem[pl_addr[9:2]] <= pl_data;
        end else if (mem_wmem != 4'b0000) begin
            for (int b = 0; b < 4; b++)
                if (mem_wmem[b]) mem[mem_addr[9:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
            if (wr_cnt < 64) begin
                wr_a[wr_cnt] <= mem_addr;
                wr_b[wr_cnt] <= mem_wmem;
            end
            wr_cnt <= wr_cnt + 1;
        end
    end

    typedef struct {
        string           name;
        logic [1:0]      sew;
        logic [31:0]     base;
        logic [31:0]     stride;
        logic [VLW-1:0]  vl;
        logic [VLEN-1:0] exp_rd;
        logic            exp_err;
        int              exp_cyc;
        int              exp_acc;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string name, input logic [VLEN-1:0] act, input logic [VLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    // Issue one request and follow it to its response; cyc = -1 if it never completes.
    task automatic run_req(input logic st, input logic [1:0] sew, input logic [31:0] base,
                           input logic [31:0] stride, input logic [VLW-1:0] vl,
                           input logic [VLEN-1:0] wd, output int cyc, output logic err,
                           output logic [VLEN-1:0] rd, output int acc);
        int guard;
        guard = 0;
        while (!req_ready && guard < 50) begin @(posedge clk); #1; guard++; end
        req_valid = 1'b1; req_store = st; req_sew = sew; req_base = base;
        req_stride = stride; req_vl = vl; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        cyc = 1; acc = 0; err = 1'b0; rd = '0;
        while (!resp_valid && cyc <= 40) begin
            if (mem_re || mem_wmem != 4'b0000) acc++;
            @(posedge clk); #1;
            cyc++;
        end
        if (resp_valid) begin
            err = resp_err;
            rd  = resp_rdata;
        end else begin
            cyc = -1;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        int              cyc, acc, c0;
        logic            err;
        logic [VLEN-1:0] rd;
        logic [VLEN-1:0] full;
        bit              seen;

        full = 128'h44444444_33333333_22222222_11111111;
        tbl[0] = '{"sew32_unit",    2'b10, 32'h100,      32'd4,        5'd4,  full, 1'b0, 5, 4};
        tbl[1] = '{"sew16_clamp",   2'b01, 32'h100,      32'd2,        5'd12, full, 1'b0, 9, 8};
        tbl[2] = '{"sew16_tail",    2'b01, 32'h100,      32'd2,        5'd3,  128'h2222_1111_1111, 1'b0, 4, 3};
        tbl[3] = '{"sew32_misalign",2'b10, 32'h10,       32'd6,        5'd4,  128'hDEADBEEF, 1'b1, 3, 1};
        tbl[4] = '{"sew32_wrap",    2'b10, 32'hFFFFFFFC, 32'd4,        5'd2,  128'h01234567_CAFEF00D, 1'b0, 3, 2};
        tbl[5] = '{"vl_zero",       2'b10, 32'h100,      32'd4,        5'd0,  128'h0, 1'b0, 1, 0};
        tbl[6] = '{"sew8_negstride",2'b00, 32'h43,       32'hFFFFFFFF, 5'd4,  128'hD4C3B2A1, 1'b0, 5, 4};
        tbl[7] = '{"sew11_clamp",   2'b11, 32'h100,      32'd4,        5'd31, full, 1'b0, 5, 4};

        // Reset values.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 128'(req_ready), 128'd1);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_valid", 128'(resp_valid), 128'd0);
        chk("rst_err", 128'(resp_err), 128'd0);
        chk("rst_rdata", resp_rdata, 128'd0);
        chk("rst_mem", {mem_addr, mem_wdata, 3'b0, mem_re, mem_wmem}, 128'd0);
        clr = 1'b0;

        preload(32'h100, 32'h11111111);
        preload(32'h104, 32'h22222222);
        preload(32'h108, 32'h33333333);
        preload(32'h10C, 32'h44444444);
        preload(32'h10,  32'hDEADBEEF);
        preload(32'h14,  32'h55555555);
        preload(32'h40,  32'hA1B2C3D4);
        preload(32'h3FC, 32'hCAFEF00D);
        preload(32'h0,   32'h01234567);
        preload(32'h200, 32'h0);
        preload(32'h204, 32'h0);
        preload(32'h208, 32'h0);
        preload(32'h210, 32'h0);

        for (int i = 0; i < 8; i++) begin
            run_req(1'b0, tbl[i].sew, tbl[i].base, tbl[i].stride, tbl[i].vl, '0, cyc, err, rd, acc);
            chk({tbl[i].name, "_rdata"}, rd, tbl[i].exp_rd);
            chk({tbl[i].name, "_err"}, 128'(err), 128'(tbl[i].exp_err));
            chk({tbl[i].name, "_cycles"}, 128'(cyc), 128'(tbl[i].exp_cyc));
            chk({tbl[i].name, "_accesses"}, 128'(acc), 128'(tbl[i].exp_acc));
        end

        // Strided byte store: 0x201, 0x206, 0x20B.
        c0 = wr_cnt;
        run_req(1'b1, 2'b00, 32'h201, 32'd5, 5'd3, 128'hCCBBAA, cyc, err, rd, acc);
        chk("bst_cycles", 128'(cyc), 128'd4);
        chk("bst_err", 128'(err), 128'd0);
        chk("bst_rdata_held", rd, full);
        chk("bst_nwr", 128'(wr_cnt - c0), 128'd3);
        chk("bst_wr0", {wr_a[c0], wr_b[c0]}, {32'h200, 4'b0010});
        chk("bst_wr1", {wr_a[c0+1], wr_b[c0+1]}, {32'h204, 4'b0100});
        chk("bst_wr2", {wr_a[c0+2], wr_b[c0+2]}, {32'h208, 4'b1000});
        chk("bst_mem0", 128'(mem[8'h80]), 128'h0000AA00);
        chk("bst_mem1", 128'(mem[8'h81]), 128'h00BB0000);
        chk("bst_mem2", 128'(mem[8'h82]), 128'hCC000000);

        // Halfword store, negative stride, both halves of one word.
        c0 = wr_cnt;
        run_req(1'b1, 2'b01, 32'h212, 32'hFFFFFFFE, 5'd2, 128'hBEEF1234, cyc, err, rd, acc);
        chk("hst_nwr", 128'(wr_cnt - c0), 128'd2);
        chk("hst_be", {wr_b[c0], wr_b[c0+1]}, {4'b1100, 4'b0011});
        chk("hst_mem", 128'(mem[8'h84]), 128'h1234BEEF);

        // Misaligned halfword store at element 0: nothing written.
        c0 = wr_cnt;
        run_req(1'b1, 2'b01, 32'h221, 32'd2, 5'd2, 128'h5678, cyc, err, rd, acc);
        chk("mst_err", 128'(err), 128'd1);
        chk("mst_cycles", 128'(cyc), 128'd2);
        chk("mst_nwr", 128'(wr_cnt - c0), 128'd0);

        // clr together with req_valid: request dropped.
        req_valid = 1'b1; req_store = 1'b0; req_sew = 2'b10; req_base = 32'h100;
        req_stride = 32'd4; req_vl = 5'd2; clr = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0; clr = 1'b0;
        chk("clr_wins_busy", 128'(busy), 128'd0);
        chk("clr_wins_ready", 128'(req_ready), 128'd1);

        // Reset during cycle 2 of a four-element store.
        c0 = wr_cnt;
        req_valid = 1'b1; req_store = 1'b1; req_sew = 2'b10; req_base = 32'h230;
        req_stride = 32'd4; req_vl = 5'd4; req_wdata = 128'h4_00000003_00000002_00000001;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        chk("rmid_wmem", 128'(mem_wmem), 128'd0);
        chk("rmid_ready", 128'(req_ready), 128'd1);
        chk("rmid_busy", 128'(busy), 128'd0);
        chk("rmid_valid", 128'(resp_valid), 128'd0);
        chk("rmid_addr_wdata", {mem_addr, mem_wdata}, 128'd0);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (resp_valid || busy) seen = 1'b1;
            @(posedge clk); #1;
        end
        chk("rmid_no_resp", 128'(seen), 128'd0);
        chk("rmid_nwr", 128'(wr_cnt - c0), 128'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
